// File: rtl/mac_pkg.sv
`default_nettype none
//==============================================================================
// Module : mac_pkg
// Shared widths, defaults and FSM state encoding for the MAC sequencer.
// Rev    : 1.0
//==============================================================================
package mac_pkg;

    localparam int OP_W       = 4;
    localparam int PROD_W     = 8;
    localparam int LEN_W_DFLT = 4;
    localparam int ACC_W_DFLT = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mac_acc_core.sv
`default_nettype none
//==============================================================================
// Module : mac_acc_core
// Gated 4x4 unsigned multiplier feeding an ACC_W accumulator with sticky carry.
// Rev    : 1.0
//==============================================================================
module mac_acc_core
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf
);

    logic [PROD_W-1:0] w_prod;
    logic [ACC_W:0]    w_sum;
    logic [ACC_W-1:0]  r_acc;
    logic              r_ovf;

    // Operands are widened first so the product keeps all eight bits.
    assign w_prod = PROD_W'(a) * PROD_W'(b);
    assign w_sum  = {1'b0, r_acc} + (ACC_W+1)'(w_prod);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (en) begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ovf <= r_ovf | w_sum[ACC_W];
        end
    end

    assign acc = r_acc;
    assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
//==============================================================================
// Module : mac_seq_ctrl
// Job sequencer: counts operand pairs into the MAC core, returns the sum.
// Rev    : 1.0
//==============================================================================
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int LEN_W = LEN_W_DFLT,
    parameter int ACC_W = ACC_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [OP_W-1:0]   op_i,
    input  logic [OP_W-1:0]   op_j,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res,
    output logic              ovf
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_cnt_nxt;
    logic               r_busy;
    logic               r_op_ready;
    logic               r_res_valid;
    logic               w_clr;
    logic               w_en;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clr       = 1'b1;
                    w_cnt_nxt   = len;
                    w_state_nxt = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (op_valid && r_op_ready) begin
                    w_en      = 1'b1;
                    w_cnt_nxt = r_cnt - LEN_W'(1);
                    if (r_cnt == LEN_W'(1)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they never see inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_op_ready  <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_busy      <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DONE);
            r_op_ready  <= (w_state_nxt == ST_RUN);
            r_res_valid <= (w_state_nxt == ST_DONE);
        end
    end

    mac_acc_core #(
        .ACC_W (ACC_W)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .en  (w_en),
        .a   (op_i),
        .b   (op_j),
        .acc (res),
        .ovf (ovf)
    );

    assign busy      = r_busy;
    assign op_ready  = r_op_ready;
    assign res_valid = r_res_valid;

endmodule
`default_nettype wire

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for the 4-bit multiply-accumulate datapath. It accepts a job of `len` operand pairs, streams them through a gated multiply-accumulate core at one pair per cycle, and returns the dot-product result on a valid/ready port. It sits between the operand source and the result consumer. It replaces free-running accumulation with explicit clear, enable, count and completion control.

## Interface
Parameters:
- LEN_W, 4: width of the job length; maximum job is 2^LEN_W−1 pairs.
- ACC_W, 12: accumulator and result width. The default holds 15×225 = 3375 without overflow.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle job request; honoured only in IDLE.
- len  in  LEN_W  number of operand pairs; sampled when start is accepted.
- busy  out  1  high in RUN and DONE.
- op_valid  in  1  operand pair present.
- op_ready  out  1  controller accepts a pair this cycle.
- op_i  in  4  unsigned multiplicand.
- op_j  in  4  unsigned multiplier.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res  out  ACC_W  accumulated sum.
- ovf  out  1  sticky; set if any accumulation carried out of ACC_W during the current job.

## Operation
- State machine IDLE → RUN → DONE → IDLE. State encoding is IDLE=0, RUN=1, DONE=2; the value 3 is illegal and recovers to IDLE.
- IDLE:
  - op_ready=0, res_valid=0, busy=0.
  - On start: cnt←len, acc←0, ovf←0.
  - Next state is RUN if len≠0. If len=0, next state is DONE and the result is 0.
- RUN:
  - op_ready=1.
  - A pair is accepted when op_valid && op_ready.
  - On each accepted pair: acc←(acc + op_i×op_j) mod 2^ACC_W, with ovf←ovf | carry-out, and cnt←cnt−1.
  - An accept with cnt=1 moves the FSM to DONE.
  - A cycle with no accept holds acc and cnt unchanged.
- DONE:
  - res_valid=1; res=acc, held stable while res_ready=0.
  - res_valid && res_ready returns the FSM to IDLE.
- res and ovf keep their last value in IDLE. They change only when the next start is accepted, which clears both.
- start asserted in RUN or DONE is ignored and does not queue.
- The product is always 8 bits unsigned and is zero-extended to ACC_W before the add.
- Reset asserted mid-job: the FSM goes to IDLE immediately, and acc, cnt and ovf are cleared. The partial job is discarded and no result is produced.

## Timing
- Reset values: busy=0, op_ready=0, res_valid=0, res=0, ovf=0, state=IDLE, cnt=0.
- start accepted in cycle T → op_ready=1 from T+1.
- Throughput is one pair per cycle with no bubbles when op_valid is held high.
- Last pair accepted in cycle T → res_valid=1 and res final in T+1. Minimum start-to-result latency is len+1 cycles.
- len=0: res_valid=1 at T+1 with res=0.
- Handshake in DONE at T → op_ready=0 and res_valid=0 at T+1. A new start is accepted no earlier than T+1.
- op_ready, res_valid and busy are decoded only from registered state and do not depend combinationally on inputs.
- All state updates occur on the clk rising edge. Only rst acts asynchronously.

## Structure
- Shared package `mac_pkg`:
  - Operand width OP_W=4 and product width PROD_W=8.
  - State constants for IDLE, RUN and DONE.
  - Default LEN_W and ACC_W.
- Sub-module `mac_acc_core`:
  - Contains the 4×4 unsigned multiplier and the ACC_W accumulator register.
  - Inputs: clk, rst, clr, en, a[3:0], b[3:0].
  - Outputs: acc, ovf.
  - clr has priority over en.
- The controller owns the FSM, the cnt down-counter and the handshake decode. It drives clr on start-accept and en on pair-accept.

## Test plan
- Reset, then a job with len=3 and pairs (3,5), (15,15), (2,7) streamed back-to-back → res_valid at cycle 4 after start, res=15+225+14=254, ovf=0.
- Job with len=2 where op_valid is withheld for 3 cycles between the pairs (4,4) and (1,9) → acc holds during the gap, res=25, done one cycle after the second accept.
- len=0 → res_valid at the next cycle with res=0. A start pulse during DONE, together with res_ready held low for 5 cycles → res stays stable, the start is ignored, and IDLE follows the handshake.
- Job with len=15 of (15,15) pairs and ACC_W=11 → res=3375 mod 2048=1327, ovf=1. A following job with len=1 of (1,1) → res=1, ovf=0.
- rst dropped after 2 of 4 pairs of a job → all outputs are 0 immediately. A fresh job with len=1 of (6,7) after reset release → res=42.
- A valid pair with op_valid high while in IDLE and no start → op_ready=0 and the accumulator is unchanged.
